exp_series_unit: RTL and testbench

Parametrised, multi-cycle fixed-point exponential unit. Evaluates e^x or e^-x for an unsigned fractional input x in [0,1) by iterating a truncated Taylor series, one term per clock. It is the generalised successor of the team's fixed 16-bit e^x block and adds:
- configurable precision and term count
- a negative-exponent mode
- a busy/done handshake
- saturation with an overflow flag

---
 rtl/exp_pkg.sv | 30 +++
 rtl/exp_recip_rom.sv | 32 +++
 rtl/exp_series_unit.sv | 129 ++++++++++++
 tb/tb_exp_series_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/exp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exp_pkg
// Description : Shared state encoding, default sizes and reciprocal helper
//               for the Taylor-series exponential unit.
// Revision    : 1.0 - initial release
// ============================================================================
package exp_pkg;

    localparam int c_frac_w = 16;
    localparam int c_int_w  = 2;
    localparam int c_terms  = 8;
    localparam int c_k_w    = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // floor(2^frac_w / k) in Q1.frac_w; k=1 yields exactly 1.0
    function automatic logic [31:0] recip(input int k, input int frac_w);
        if (k < 1) begin
            return 32'd0;
        end
        return 32'((64'd1 << frac_w) / 64'(k));
    endfunction

endpackage
`default_nettype wire

// File: rtl/exp_recip_rom.sv
`default_nettype none
// ============================================================================
// Module      : exp_recip_rom
// Description : Combinational lookup k -> floor(2^FRAC_W / k), k = 1..TERMS.
// Revision    : 1.0 - initial release
// ============================================================================
module exp_recip_rom
    import exp_pkg::*;
#(
    parameter int FRAC_W = c_frac_w,
    parameter int TERMS  = c_terms
) (
    input  logic [c_k_w-1:0] i_k,
    output logic [FRAC_W:0]  o_recip
);

    logic [FRAC_W:0] w_table [0:(2**c_k_w)-1];

    generate
        for (genvar gi = 0; gi < 2**c_k_w; gi++) begin : g_entry
            if (gi >= 1 && gi <= TERMS) begin : g_live
                assign w_table[gi] = (FRAC_W+1)'(recip(gi, FRAC_W));
            end else begin : g_zero
                assign w_table[gi] = '0;
            end
        end
    endgenerate

    assign o_recip = w_table[i_k];

endmodule
`default_nettype wire

// File: rtl/exp_series_unit.sv
`default_nettype none
// ============================================================================
// Module      : exp_series_unit
// Description : Multi-cycle e^x / e^-x for x in [0,1), one Taylor term per clk.
// Revision    : 1.0 - initial release
// ============================================================================
module exp_series_unit
    import exp_pkg::*;
#(
    parameter int FRAC_W = c_frac_w,
    parameter int INT_W  = c_int_w,
    parameter int TERMS  = c_terms
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              neg,
    input  logic [FRAC_W-1:0] x,
    output logic              busy,
    output logic              done,
    output logic [INT_W-1:0]  intpart,
    output logic [FRAC_W-1:0] fracpart,
    output logic              ovf
);

    localparam int                 c_acc_w    = INT_W + FRAC_W + 2;
    localparam logic [c_k_w-1:0]   c_last     = c_k_w'(TERMS);
    localparam logic [FRAC_W:0]    c_one_term = {1'b1, {FRAC_W{1'b0}}};
    localparam logic [c_acc_w-1:0] c_one_acc  = {{(INT_W+1){1'b0}}, 1'b1, {FRAC_W{1'b0}}};

    state_t               r_state;
    logic [FRAC_W-1:0]    r_x;
    logic                 r_neg;
    logic [c_k_w-1:0]     r_k;
    logic [FRAC_W:0]      r_term;
    logic [c_acc_w-1:0]   r_acc;

    logic [FRAC_W:0]      w_recip;
    logic [2*FRAC_W:0]    w_prod1;
    logic [FRAC_W:0]      w_p;
    logic [2*FRAC_W+1:0]  w_prod2;
    logic [FRAC_W:0]      w_t;
    logic [c_acc_w-1:0]   w_t_ext;
    logic [c_acc_w-1:0]   w_acc_next;
    logic                 w_sub;
    logic                 w_unused;

    exp_recip_rom #(
        .FRAC_W (FRAC_W),
        .TERMS  (TERMS)
    ) u_rom (
        .i_k     (r_k),
        .o_recip (w_recip)
    );

    assign w_prod1    = {{FRAC_W{1'b0}}, r_term} * {{(FRAC_W+1){1'b0}}, r_x};
    assign w_p        = w_prod1[2*FRAC_W:FRAC_W];
    assign w_prod2    = {{(FRAC_W+1){1'b0}}, w_p} * {{(FRAC_W+1){1'b0}}, w_recip};
    assign w_t        = w_prod2[2*FRAC_W:FRAC_W];
    assign w_t_ext    = {{(INT_W+1){1'b0}}, w_t};
    // Odd powers of -x carry a minus sign in the e^-x series
    assign w_sub      = r_neg & r_k[0];
    assign w_acc_next = w_sub ? (r_acc - w_t_ext) : (r_acc + w_t_ext);
    assign w_unused   = ^{w_prod1[FRAC_W-1:0], w_prod2[FRAC_W-1:0], w_prod2[2*FRAC_W+1]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_x      <= '0;
            r_neg    <= 1'b0;
            r_k      <= '0;
            r_term   <= '0;
            r_acc    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            intpart  <= '0;
            fracpart <= '0;
            ovf      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_x     <= x;
                        r_neg   <= neg;
                        r_term  <= c_one_term;
                        r_acc   <= c_one_acc;
                        r_k     <= c_k_w'(1);
                        busy    <= 1'b1;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_term <= w_t;
                    r_acc  <= w_acc_next;
                    r_k    <= r_k + c_k_w'(1);
                    if (r_k == c_last) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        // Sign bit set cannot occur for x<1; clamp defensively
                        if (w_acc_next[c_acc_w-1]) begin
                            intpart  <= '0;
                            fracpart <= '0;
                            ovf      <= 1'b0;
                        end else if (w_acc_next[c_acc_w-2]) begin
                            intpart  <= '1;
                            fracpart <= '1;
                            ovf      <= 1'b1;
                        end else begin
                            intpart  <= w_acc_next[FRAC_W+INT_W-1:FRAC_W];
                            fracpart <= w_acc_next[FRAC_W-1:0];
                            ovf      <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exp_series_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_exp_series_unit
// Description : Directed self-checking bench for exp_series_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exp_series_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        neg;
    logic [15:0] x;

    logic        busy, done, ovf;
    logic [1:0]  intpart;
    logic [15:0] fracpart;

    logic        busy1, done1, ovf1;
    logic [0:0]  intpart1;
    logic [15:0] fracpart1;

    int checks   = 0;
    int failures = 0;

    exp_series_unit #(.FRAC_W(16), .INT_W(2), .TERMS(8)) dut (
        .clk(clk), .rst(rst), .start(start), .neg(neg), .x(x),
        .busy(busy), .done(done), .intpart(intpart), .fracpart(fracpart), .ovf(ovf)
    );

    exp_series_unit #(.FRAC_W(16), .INT_W(1), .TERMS(8)) dut1 (
        .clk(clk), .rst(rst), .start(start), .neg(neg), .x(x),
        .busy(busy1), .done(done1), .intpart(intpart1), .fracpart(fracpart1), .ovf(ovf1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s failed", tag);
        end
    endtask

    task automatic chk_near(input string tag, input longint obs, input longint exp, input longint tol);
        checks++;
        assert ((obs >= exp - tol) && (obs <= exp + tol)) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h+-%0d", tag, obs, exp, tol);
            $error("check %s failed", tag);
        end
    endtask

    // Launch one operation and wait for done; returns latency and busy-cycle count
    task automatic run(input logic [15:0] xv, input logic nv, output int lat, output int bcnt);
        start = 1'b1;
        x     = xv;
        neg   = nv;
        tick();
        start = 1'b0;
        lat   = 0;
        bcnt  = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat, bcnt, ndone, cyc, last, nd;
        logic        saw;
        logic [1:0]  cap_int;
        logic [15:0] cap_frac;
        logic        cap_ovf1;

        rst = 1'b0; start = 1'b0; neg = 1'b0; x = '0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_int",  intpart, 0);
        chk("rst_frac", fracpart, 0);
        chk("rst_ovf",  ovf, 0);
        chk("rst_ovf1", ovf1, 0);
        rst = 1'b1;
        tick();

        // x = 0 gives exactly 1.0
        run(16'h0000, 1'b0, lat, bcnt);
        chk("x0_latency", lat, 8);
        chk("x0_int",  intpart, 1);
        chk("x0_frac", fracpart, 16'h0000);
        chk("x0_ovf",  ovf, 0);
        tick();
        chk("x0_done_pulse", done, 0);

        // e^0.375
        run(16'h6000, 1'b0, lat, bcnt);
        chk("x375_busy_cycles", bcnt, 8);
        chk("x375_int", intpart, 1);
        chk_near("x375_frac", fracpart, 16'h747A, 8);
        chk("x375_int_w1", intpart1, 1);
        chk("x375_ovf_w1", ovf1, 0);
        repeat (2) tick();

        // e^0.9267, with a second start pulse three cycles into the run
        start = 1'b1; x = 16'hED3C; neg = 1'b0;
        tick();
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1; x = 16'h0000;
        tick();
        start = 1'b0;
        ndone = 0; cap_int = '0; cap_frac = '0; cap_ovf1 = 1'b0;
        repeat (25) begin
            if (done) begin
                ndone++;
                cap_int  = intpart;
                cap_frac = fracpart;
                cap_ovf1 = ovf1;
            end
            tick();
        end
        chk("ignore_start_ndone", ndone, 1);
        chk("x9267_int", cap_int, 2);
        chk_near("x9267_frac", cap_frac, 16'h86B1, 8);
        chk("x9267_ovf_w1", cap_ovf1, 1);

        // e^-0.5
        run(16'h8000, 1'b1, lat, bcnt);
        chk("neg05_int", intpart, 0);
        chk_near("neg05_frac", fracpart, 16'h9B46, 8);
        chk("neg05_ovf", ovf, 0);
        repeat (2) tick();

        // e^0.75 saturates with one integer bit
        run(16'hC000, 1'b0, lat, bcnt);
        chk("sat_int_w1",  intpart1, 1);
        chk("sat_frac_w1", fracpart1, 16'hFFFF);
        chk("sat_ovf_w1",  ovf1, 1);
        chk("x75_int", intpart, 2);
        chk("x75_ovf", ovf, 0);
        repeat (2) tick();

        // Reset mid-calculation
        start = 1'b1; x = 16'h6000; neg = 1'b0;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_int",  intpart, 0);
        chk("midrst_frac", fracpart, 0);
        chk("midrst_ovf",  ovf, 0);
        saw = 1'b0;
        repeat (15) begin
            if (done) saw = 1'b1;
            tick();
        end
        chk("midrst_no_done", saw, 0);
        run(16'h6000, 1'b0, lat, bcnt);
        chk("after_rst_latency", lat, 8);
        chk("after_rst_int", intpart, 1);
        chk_near("after_rst_frac", fracpart, 16'h747A, 8);
        repeat (2) tick();

        // Back-to-back with start held; 0xA612 is the fraction of e^0.5
        start = 1'b1; x = 16'h8000; neg = 1'b0;
        cyc = 0; last = 0; nd = 0;
        while (nd < 3 && cyc < 60) begin
            tick();
            cyc++;
            if (done) begin
                if (nd > 0) chk("b2b_gap", cyc - last, 10);
                last = cyc;
                chk("b2b_int", intpart, 1);
                chk_near("b2b_frac", fracpart, 16'hA612, 8);
                nd++;
            end
        end
        chk("b2b_count", nd, 3);
        start = 1'b0;
        repeat (12) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
